// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, per-length
// constants and the GF(2^8) xtime helper.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'b00,
    KEY_192 = 2'b01,
    KEY_256 = 2'b10,
    KEY_RSV = 2'b11
  } key_len_e;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } ks_state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [5:0] TOTAL_128 = 6'd44;
  localparam logic [5:0] TOTAL_192 = 6'd52;
  localparam logic [5:0] TOTAL_256 = 6'd60;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEY_192: return NK_192;
      KEY_256: return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEY_192: return NR_192;
      KEY_256: return NR_256;
      default: return NR_128;
    endcase
  endfunction

  function automatic logic [5:0] total_of(input logic [1:0] len);
    case (len)
      KEY_192: return TOTAL_192;
      KEY_256: return TOTAL_256;
      default: return TOTAL_128;
    endcase
  endfunction

  function automatic int key_bits_of(input logic [1:0] len);
    return 128 + 64 * int'(len);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// standard affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] INV_EXP = 8'hfe;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // x^254 is the inverse for x != 0 and conveniently maps 0 to 0
  always_comb begin
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (INV_EXP[i]) inv = gf_mul(inv, data_i);
    end
  end

  assign data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// Word-serial AES-128/192/256 key expander streaming 128-bit round keys
// over a valid/ready interface with backpressure.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         done
);

  ks_state_e    state_q;
  logic [2:0]   nkm1_q;
  logic [3:0]   nr_q;
  logic [5:0]   total_q;
  logic [5:0]   wcnt_q;
  logic [2:0]   mod_q;
  logic [7:0]   rcon_q;
  logic [255:0] key_q;
  logic [31:0]  win_q [8];
  logic [31:0]  buf_q [3];
  logic         err_q;
  logic         rk_valid_q;
  logic         rk_last_q;
  logic [127:0] rk_data_q;
  logic [3:0]   rk_index_q;

  logic        len_legal, start_ok, stall, gen, xfer, in_key, rot_path;
  logic [31:0] sub_in, sub_out, temp, word_d;

  assign len_legal = (key_len != KEY_RSV) && (key_bits_of(key_len) <= MAX_KEY_BITS);
  assign start_ok  = start && (state_q == IDLE) && len_legal;
  assign stall     = rk_valid_q && !rk_ready;
  assign xfer      = rk_valid_q && rk_ready;
  assign gen       = (state_q == GEN) && (wcnt_q != total_q) && !stall;
  assign in_key    = wcnt_q <= {3'b000, nkm1_q};
  assign rot_path  = mod_q == 3'd0;

  // One SubWord serves both the RotWord step and the Nk=8 mid-key step
  assign sub_in = rot_path ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i(sub_in[8*b +: 8]),
      .data_o(sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = win_q[0];
    if (rot_path) begin
      temp = sub_out ^ {rcon_q, 24'h000000};
    end else if (nkm1_q == 3'd7 && mod_q == 3'd4) begin
      temp = sub_out;
    end
    word_d = in_key ? key_q[255:224] : (win_q[nkm1_q] ^ temp);
  end

  // win_q[0] is the newest word, so w[i-Nk] sits at win_q[Nk-1]
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      nkm1_q     <= 3'd3;
      nr_q       <= NR_128;
      total_q    <= TOTAL_128;
      wcnt_q     <= 6'd0;
      mod_q      <= 3'd0;
      rcon_q     <= 8'h01;
      key_q      <= '0;
      for (int k = 0; k < 8; k++) win_q[k] <= 32'h0;
      for (int k = 0; k < 3; k++) buf_q[k] <= 32'h0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      rk_data_q  <= '0;
      rk_index_q <= 4'd0;
    end else begin
      err_q <= start && (state_q == IDLE) && !len_legal;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= GEN;
            key_q   <= key_in;
            nkm1_q  <= 3'(nk_of(key_len) - 4'd1);
            nr_q    <= nr_of(key_len);
            total_q <= total_of(key_len);
            wcnt_q  <= 6'd0;
            mod_q   <= 3'd0;
            rcon_q  <= 8'h01;
          end
        end
        GEN: begin
          if (xfer) begin
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            if (rk_last_q) state_q <= IDLE;
          end
          if (gen) begin
            win_q[0] <= word_d;
            for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
            key_q  <= {key_q[223:0], 32'h0};
            wcnt_q <= wcnt_q + 6'd1;
            mod_q  <= (mod_q == nkm1_q) ? 3'd0 : mod_q + 3'd1;
            if (!in_key && rot_path) rcon_q <= xtime(rcon_q);
            case (wcnt_q[1:0])
              2'd0: buf_q[0] <= word_d;
              2'd1: buf_q[1] <= word_d;
              2'd2: buf_q[2] <= word_d;
              default: begin
                rk_data_q  <= {buf_q[0], buf_q[1], buf_q[2], word_d};
                rk_index_q <= wcnt_q[5:2];
                rk_last_q  <= wcnt_q[5:2] == nr_q;
                rk_valid_q <= 1'b1;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = state_q == GEN;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_index = rk_index_q;
  assign rk_last  = rk_last_q;
  assign done     = !rst && rk_valid_q && rk_ready && rk_last_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, start2, rk_ready, rk_ready2;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, err, rk_valid, rk_last, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         busy2, err2, rk_valid2, rk_last2, done2;
  logic [127:0] rk_data2;
  logic [3:0]   rk_index2;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last), .done(done)
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len), .key_in(key_in),
    .busy(busy2), .err(err2), .rk_valid(rk_valid2), .rk_ready(rk_ready2),
    .rk_data(rk_data2), .rk_index(rk_index2), .rk_last(rk_last2), .done(done2)
  );

  // Low 128 bits of the AES-128 key are junk that the block must ignore
  localparam logic [255:0] KEY128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                                     128'hdeadbeef_cafef00d_01234567_89abcdef};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b,
                                     64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  localparam logic [127:0] EXP128 [11] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e,
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
  };

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         last;
    logic         chk;
  } beat_t;

  beat_t  sb[$];
  int     tests = 0;
  int     errors = 0;
  logic   randMode = 1'b0;
  logic   prevStall = 1'b0;
  logic [127:0] prevData;
  logic [3:0]   prevIdx;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hand-derived round keys; rounds without a known value are checked for index/last only
  task automatic knownRound(input logic [1:0] len, input int r, output logic [127:0] d, output logic chk);
    d   = '0;
    chk = 1'b0;
    case (len)
      2'd0: begin d = EXP128[r]; chk = 1'b1; end
      2'd1: begin
        if (r == 0)  begin d = KEY192[255:128]; chk = 1'b1; end
        if (r == 1)  begin d = {KEY192[127:64], 64'hfe0c91f7_2402f5a5}; chk = 1'b1; end
        if (r == 12) begin d = 128'he98ba06f_448c773c_8ecc7204_01002202; chk = 1'b1; end
      end
      default: begin
        if (r == 0)  begin d = KEY256[255:128]; chk = 1'b1; end
        if (r == 1)  begin d = KEY256[127:0]; chk = 1'b1; end
        if (r == 2)  begin d = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde; chk = 1'b1; end
        if (r == 3)  begin d = 128'ha8b09c1a_93d194cd_be49846e_b75d5b9a; chk = 1'b1; end
        if (r == 14) begin d = 128'hfe4890d1_e6188d0b_046df344_706c631e; chk = 1'b1; end
      end
    endcase
  endtask

  // Pushes the expected beats (up to nbeats) then pulses start for one edge
  task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key, input int nbeats);
    int    nr;
    beat_t e;
    nr = (len == 2'd0) ? 10 : (len == 2'd1) ? 12 : 14;
    for (int r = 0; r <= nr && r < nbeats; r++) begin
      e.idx  = 4'(r);
      e.last = (r == nr);
      knownRound(len, r, e.data, e.chk);
      sb.push_back(e);
    end
    key_len = len;
    key_in  = key;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int limit);
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) break;
    end
    checkOutput({name, "_complete"}, {127'h0, (!busy && sb.size() == 0)}, 128'h1);
    checkOutput({name, "_beats_left"}, 128'(sb.size()), 128'h0);
    sb.delete();
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_busy"}, {127'h0, busy}, 128'h0);
    checkOutput({name, "_err"}, {127'h0, err}, 128'h0);
    checkOutput({name, "_rk_valid"}, {127'h0, rk_valid}, 128'h0);
    checkOutput({name, "_rk_last"}, {127'h0, rk_last}, 128'h0);
    checkOutput({name, "_done"}, {127'h0, done}, 128'h0);
    checkOutput({name, "_rk_data"}, rk_data, 128'h0);
    checkOutput({name, "_rk_index"}, {124'h0, rk_index}, 128'h0);
  endtask

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_ready = randMode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and watches stalls
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_rk_data", rk_data, prevData);
        checkOutput("stall_rk_index", {124'h0, rk_index}, {124'h0, prevIdx});
      end
      if (rk_valid && rk_ready) begin
        checkOutput("beat_expected", {127'h0, sb.size() != 0}, 128'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("rk_index", {124'h0, rk_index}, {124'h0, e.idx});
          checkOutput("rk_last", {127'h0, rk_last}, {127'h0, e.last});
          checkOutput("done", {127'h0, done}, {127'h0, e.last});
          if (e.chk) checkOutput($sformatf("rk_data_r%0d", e.idx), rk_data, e.data);
        end
      end else if (done) begin
        checkOutput("done_without_transfer", {127'h0, done}, 128'h0);
      end
      prevStall = rk_valid && !rk_ready;
      prevData  = rk_data;
      prevIdx   = rk_index;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; rk_ready2 = 1'b1;
    key_len = 2'd0; key_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkResetValues("reset");

    // AES-128 with first-beat latency checks
    applyStimulus(2'd0, KEY128, 11);
    checkOutput("busy_after_start", {127'h0, busy}, 128'h1);
    repeat (3) @(posedge clk); #1;
    checkOutput("valid_before_e4", {127'h0, rk_valid}, 128'h0);
    @(posedge clk); #1;
    checkOutput("valid_after_e4", {127'h0, rk_valid}, 128'h1);
    waitIdle("aes128", 200);

    applyStimulus(2'd1, KEY192, 13);
    waitIdle("aes192", 200);

    applyStimulus(2'd2, KEY256, 15);
    waitIdle("aes256", 200);

    randMode = 1'b1;
    applyStimulus(2'd2, KEY256, 15);
    waitIdle("aes256_throttled", 3000);
    randMode = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reserved key length
    key_len = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("err_reserved", {127'h0, err}, 128'h1);
    checkOutput("busy_reserved", {127'h0, busy}, 128'h0);
    @(posedge clk); #1;
    checkOutput("err_one_cycle", {127'h0, err}, 128'h0);

    // Key lengths above MAX_KEY_BITS=128
    for (int l = 1; l <= 2; l++) begin
      key_len = 2'(l); start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      checkOutput($sformatf("small_err_len%0d", l), {127'h0, err2}, 128'h1);
      checkOutput($sformatf("small_busy_len%0d", l), {127'h0, busy2}, 128'h0);
    end
    key_len = 2'd0; key_in = KEY128; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    checkOutput("small_accept_128", {126'h0, busy2, err2}, 128'h2);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done2) break;
    end
    checkOutput("small_done", {127'h0, done2}, 128'h1);
    checkOutput("small_last_data", rk_data2, EXP128[10]);
    checkOutput("small_last_index", {123'h0, rk_last2, rk_index2}, {123'h0, 1'b1, 4'd10});
    checkOutput("small_rk_valid", {127'h0, rk_valid2}, 128'h1);
    @(posedge clk); #1;
    checkOutput("small_busy_drop", {127'h0, busy2}, 128'h0);

    // Start while busy must be ignored without err
    applyStimulus(2'd0, KEY128, 11);
    repeat (5) @(posedge clk); #1;
    key_len = 2'd3; key_in = KEY256; start = 1'b1;
    @(posedge clk); #1;
    key_len = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_start_no_err", {127'h0, err}, 128'h0);
    checkOutput("busy_start_still_busy", {127'h0, busy}, 128'h1);
    waitIdle("aes128_busy_start", 200);

    // Abort AES-192 after round 5, then restart AES-128
    applyStimulus(2'd1, KEY192, 6);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    checkOutput("aes192_r5_reached", 128'(sb.size()), 128'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetValues("abort");
    repeat (8) @(posedge clk); #1;
    checkOutput("abort_stays_idle", {126'h0, busy, rk_valid}, 128'h0);

    applyStimulus(2'd0, KEY128, 11);
    waitIdle("aes128_restart", 200);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
